// File: rtl/thermo_enc_arbiter.sv
// thermo_enc_arbiter: round-robin shared thermometer encoder with registered result stage
module thermo_enc_arbiter #(
  parameter int M     = 8,
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_a_valid,
  input  logic [M-1:0]     i_a_data,
  output logic             o_a_ready,
  input  logic             i_b_valid,
  input  logic [M-1:0]     i_b_data,
  output logic             o_b_ready,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [M-1:0]     o_thermo,
  output logic             o_vf,
  output logic             o_id,
  output logic [CNT_W-1:0] o_a_vf_cnt,
  output logic [CNT_W-1:0] o_b_vf_cnt
);
  typedef enum logic {EMPTY, FULL} state_t;
  localparam logic [M:0] M_V = (M+1)'(M);
  state_t           state_q;
  logic             rr_q;
  logic [M-1:0]     thermo_q, thermo_d, sel_data;
  logic             vf_q, vf_d, id_q;
  logic [CNT_W-1:0] a_cnt_q, b_cnt_q;
  logic             grant_a, grant_b, can_accept, xfer;
  // rr_q = 0 gives A priority when both are valid
  assign grant_b    = i_b_valid & (~i_a_valid | rr_q);
  assign grant_a    = i_a_valid & ~grant_b;
  assign can_accept = (state_q == EMPTY) | i_ready;
  assign o_a_ready  = grant_a & can_accept;
  assign o_b_ready  = grant_b & can_accept;
  assign xfer       = o_a_ready | o_b_ready;
  assign sel_data   = grant_b ? i_b_data : i_a_data;
  always_comb begin
    thermo_d = '0;
    for (int i = 0; i < M; i++)
      thermo_d[i] = {1'b0, sel_data} > (M+1)'(i);
    thermo_d = (sel_data == '0) ? '0 : thermo_d;
    vf_d     = {1'b0, sel_data} > M_V;
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q  <= EMPTY;
      rr_q     <= 1'b0;
      thermo_q <= '0;
      vf_q     <= 1'b0;
      id_q     <= 1'b0;
      a_cnt_q  <= '0;
      b_cnt_q  <= '0;
    end else begin
      if (xfer) begin
        state_q  <= FULL;
        thermo_q <= thermo_d;
        vf_q     <= vf_d;
        id_q     <= grant_b;
        rr_q     <= grant_a;
      end else if (i_ready) begin
        state_q  <= EMPTY;
      end
      if (o_a_ready && vf_d && !(&a_cnt_q)) a_cnt_q <= a_cnt_q + 1'b1;
      if (o_b_ready && vf_d && !(&b_cnt_q)) b_cnt_q <= b_cnt_q + 1'b1;
    end
  end
  assign o_valid    = (state_q == FULL);
  assign o_thermo   = thermo_q;
  assign o_vf       = vf_q;
  assign o_id       = id_q;
  assign o_a_vf_cnt = a_cnt_q;
  assign o_b_vf_cnt = b_cnt_q;
endmodule

// File: tb/tb_thermo_enc_arbiter.sv
// tb_thermo_enc_arbiter: table-driven vectors with a result scoreboard and hand-written reset cases
module tb_thermo_enc_arbiter;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       a_valid = 1'b0, b_valid = 1'b0, rdy = 1'b0;
  logic [7:0] a_data = '0, b_data = '0;
  logic       o_a_ready, o_b_ready, o_valid, o_vf, o_id;
  logic [7:0] o_thermo;
  logic [1:0] o_a_vf_cnt, o_b_vf_cnt;
  int         n_chk = 0, n_fail = 0;

  typedef struct {
    logic       av;
    logic [7:0] ad;
    logic       bv;
    logic [7:0] bd;
    logic       rdy;
    logic       ea;
    logic       eb;
  } vec_t;

  typedef struct {
    logic [7:0] t;
    logic       vf;
    logic       id;
  } res_t;

  vec_t       vecs[$];
  res_t       sb[$];
  logic [1:0] acnt = '0, bcnt = '0;

  thermo_enc_arbiter #(.M(8), .CNT_W(2)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_a_valid(a_valid), .i_a_data(a_data), .o_a_ready(o_a_ready),
    .i_b_valid(b_valid), .i_b_data(b_data), .o_b_ready(o_b_ready),
    .o_valid(o_valid), .i_ready(rdy),
    .o_thermo(o_thermo), .o_vf(o_vf), .o_id(o_id),
    .o_a_vf_cnt(o_a_vf_cnt), .o_b_vf_cnt(o_b_vf_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // {vf, thermo} computed as a mask rather than bit by bit
  function automatic logic [8:0] enc(input logic [7:0] a);
    logic [7:0] t;
    t = (a >= 8'd8) ? 8'hFF : 8'((9'd1 << a) - 9'd1);
    return {a > 8'd8, t};
  endfunction

  task automatic add(input logic av, input logic [7:0] ad, input logic bv, input logic [7:0] bd,
                     input logic r, input logic ea, input logic eb);
    vecs.push_back('{av, ad, bv, bd, r, ea, eb});
  endtask

  task automatic step(input vec_t v);
    res_t       e;
    logic [8:0] r;
    @(negedge clk);
    a_valid = v.av; a_data = v.ad; b_valid = v.bv; b_data = v.bd; rdy = v.rdy;
    #1;
    chk("a_ready", 32'(o_a_ready), 32'(v.ea));
    chk("b_ready", 32'(o_b_ready), 32'(v.eb));
    chk("valid", 32'(o_valid), 32'(sb.size() != 0));
    chk("a_cnt", 32'(o_a_vf_cnt), 32'(acnt));
    chk("b_cnt", 32'(o_b_vf_cnt), 32'(bcnt));
    if (sb.size() != 0) begin
      e = sb[0];
      chk("thermo", 32'(o_thermo), 32'(e.t));
      chk("vf", 32'(o_vf), 32'(e.vf));
      chk("id", 32'(o_id), 32'(e.id));
      if (v.rdy) void'(sb.pop_front());
    end
    if (v.ea || v.eb) begin
      r = enc(v.ea ? v.ad : v.bd);
      sb.push_back('{r[7:0], r[8], v.eb});
      if (r[8] && v.ea && acnt != 2'd3) acnt++;
      if (r[8] && v.eb && bcnt != 2'd3) bcnt++;
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_valid"}, 32'(o_valid), 32'd0);
    chk({tag, "_thermo"}, 32'(o_thermo), 32'd0);
    chk({tag, "_vf"}, 32'(o_vf), 32'd0);
    chk({tag, "_id"}, 32'(o_id), 32'd0);
    chk({tag, "_acnt"}, 32'(o_a_vf_cnt), 32'd0);
    chk({tag, "_bcnt"}, 32'(o_b_vf_cnt), 32'd0);
  endtask

  initial begin
    // single request, then boundary operands on B
    add(1, 8'd3,   0, 8'd0,   1, 1, 0);
    add(0, 8'd0,   0, 8'd0,   1, 0, 0);
    add(0, 8'd0,   1, 8'd0,   1, 0, 1);
    add(0, 8'd0,   1, 8'd8,   1, 0, 1);
    add(0, 8'd0,   1, 8'd9,   1, 0, 1);
    add(0, 8'd0,   1, 8'd255, 1, 0, 1);
    add(0, 8'd0,   0, 8'd0,   1, 0, 0);
    // contention: A first, then alternating
    add(1, 8'd1,   1, 8'd2,   1, 1, 0);
    add(1, 8'd4,   1, 8'd5,   1, 0, 1);
    add(1, 8'd6,   1, 8'd7,   1, 1, 0);
    add(1, 8'd10,  1, 8'd2,   1, 0, 1);
    add(0, 8'd0,   0, 8'd0,   1, 0, 0);
    // backpressure for 4 cycles, then drain and accept together
    add(1, 8'd5,   0, 8'd0,   1, 1, 0);
    add(1, 8'd6,   0, 8'd0,   0, 0, 0);
    add(1, 8'd6,   0, 8'd0,   0, 0, 0);
    add(1, 8'd6,   0, 8'd0,   0, 0, 0);
    add(1, 8'd6,   0, 8'd0,   0, 0, 0);
    add(1, 8'd6,   0, 8'd0,   1, 1, 0);
    add(0, 8'd0,   0, 8'd0,   1, 0, 0);
    // A counter saturation at 3
    add(1, 8'd20,  0, 8'd0,   1, 1, 0);
    add(1, 8'd20,  0, 8'd0,   1, 1, 0);
    add(1, 8'd20,  0, 8'd0,   1, 1, 0);
    add(1, 8'd20,  0, 8'd0,   1, 1, 0);
    add(0, 8'd0,   0, 8'd0,   1, 0, 0);
    add(1, 8'd20,  0, 8'd0,   0, 1, 0);
    add(0, 8'd0,   0, 8'd0,   0, 0, 0);

    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    #1;
    chk_reset_state("rst");
    chk("rst_a_ready", 32'(o_a_ready), 32'd0);
    chk("rst_b_ready", 32'(o_b_ready), 32'd0);
    rst_n = 1'b1;

    foreach (vecs[k]) step(vecs[k]);

    // reset while FULL discards the pending result and clears counters
    @(negedge clk);
    rst_n = 1'b0;
    chk("pre_rst_valid", 32'(o_valid), 32'd1);
    @(negedge clk);
    #1;
    chk_reset_state("mid_rst");
    sb.delete();
    acnt = '0;
    bcnt = '0;
    rst_n = 1'b1;
    step('{1'b0, 8'd0, 1'b1, 8'd2, 1'b1, 1'b0, 1'b1});
    step('{1'b1, 8'd8, 1'b1, 8'd9, 1'b1, 1'b1, 1'b0});
    step('{1'b0, 8'd0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0});
    step('{1'b0, 8'd0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/thermo_enc_arbiter.md
Name: thermo_enc_arbiter

Overview:
- Shares one thermometer encoding resource of width M between two requesters, A and B.
- Each requester has a valid/ready handshake. A round-robin grant picks one request per accepted transaction.
- The block encodes the granted operand and returns the result through a single registered output stage with valid/ready and a requester tag.
- Sits in SPI_EXE_UNIT_2 between the execution-unit command decode and the downstream result mux. It also keeps saturating overflow counters per requester.

Parameters:
- M, 8, operand and thermometer-code width in bits.
- CNT_W, 8, width of each per-requester overflow counter.

Ports:
- i_clk  input  1  clock; all state changes on the rising edge.
- i_rst_n  input  1  synchronous active-low reset.
- i_a_valid  input  1  requester A has an operand.
- i_a_data  input  M  requester A operand (unsigned).
- o_a_ready  output  1  requester A operand accepted this cycle.
- i_b_valid  input  1  requester B has an operand.
- i_b_data  input  M  requester B operand (unsigned).
- o_b_ready  output  1  requester B operand accepted this cycle.
- o_valid  output  1  result register holds a valid result.
- i_ready  input  1  downstream consumes the result when o_valid and i_ready are both high.
- o_thermo  output  M  registered thermometer code.
- o_vf  output  1  registered overflow flag.
- o_id  output  1  source of the result: 0 = A, 1 = B.
- o_a_vf_cnt  output  CNT_W  saturating count of A results with vf = 1.
- o_b_vf_cnt  output  CNT_W  saturating count of B results with vf = 1.

Behaviour:
- Reset (i_rst_n low at a clock edge) clears everything:
  - o_valid, o_thermo, o_vf, o_id and both counters go to 0.
  - The state machine goes to EMPTY.
  - The round-robin pointer is set so that A has priority next.
  - A mid-transaction result is discarded, not delivered.
- Encoding function for operand a, in the combinational path before the result register:
  - thermo[i] = 1 for every i < min(a, M); all other bits are 0.
  - vf = 1 exactly when a > M.
  - a = 0 gives thermo = 0 and vf = 0; the block forces this case explicitly.
  - a = M gives all ones and vf = 0.
- State machine, two states:
  - EMPTY: output register invalid; o_valid = 0.
  - FULL: output register valid; o_valid = 1.
- The block can accept a request (can_accept) when the state is EMPTY, or when it is FULL and i_ready = 1 in the same cycle (pass-through drain).
- Arbitration, evaluated combinationally each cycle:
  - If only one of A or B is valid, that one is granted.
  - If both are valid, the one indicated by the rr pointer is granted.
  - o_x_ready = grant_x AND can_accept. At most one ready is high per cycle.
  - The rr pointer flips to the non-granted requester only when a transfer occurs.
  - A requester not granted must hold its valid and data stable; the block does not latch it.
- Transfers and state transitions:
  - On an accept, the encoded result, vf and id load into the output register at the next edge. Latency is one cycle from the accept edge to o_valid.
  - EMPTY to FULL on accept.
  - FULL stays FULL on simultaneous drain and accept; this gives one result per cycle.
  - FULL to EMPTY on drain with no accept.
  - FULL with i_ready = 0 holds o_thermo, o_vf and o_id stable; no ready is asserted.
- Counters:
  - On each accept whose encoded vf = 1, the granted requester's counter increments.
  - Each counter saturates at all ones and never wraps.
  - Counters are cleared only by reset.

Test Plan:
- Reset then idle: i_rst_n low for 2 cycles -> all outputs 0 and o_a_ready = o_b_ready = 0 while both valids are low.
- Single request: A valid with data 3 and i_ready = 1 -> o_a_ready = 1 that cycle; next cycle o_valid = 1, o_thermo = 8'b0000_0111, o_vf = 0, o_id = 0.
- Boundary operands on B with M = 8:
  - data 0 -> thermo 8'h00, vf 0.
  - data 8 -> thermo 8'hFF, vf 0.
  - data 9 -> thermo 8'hFF, vf 1, o_b_vf_cnt = 1.
  - data 255 -> thermo 8'hFF, vf 1, o_b_vf_cnt = 2.
- Contention: A and B both valid every cycle, i_ready = 1 -> grants alternate A, B, A, B starting with A after reset; o_id sequence is 0, 1, 0, 1; one result per cycle.
- Backpressure: result FULL with i_ready = 0 for 4 cycles and A valid -> o_a_ready stays 0 and outputs hold; when i_ready rises, the drain and A's accept happen in the same cycle and o_valid stays 1.
- Saturation and reset mid-operation: with CNT_W = 2, four A operands of 20 -> o_a_vf_cnt goes 1, 2, 3, 3. Asserting i_rst_n low while FULL -> o_valid = 0 and counters = 0 next edge.
